// File: rtl/intr85_pkg.sv
// Shared constants for the core85 interrupt controller: source codes, restart
// vectors, SIM/RIM bit positions and pin indices.
package intr85_pkg;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_TRAP = 3'd1,
    SRC_R75  = 3'd2,
    SRC_R65  = 3'd3,
    SRC_R55  = 3'd4,
    SRC_INTR = 3'd5
  } src_e;

  localparam logic [15:0] VEC_TRAP = 16'h0024;
  localparam logic [15:0] VEC_R75  = 16'h003C;
  localparam logic [15:0] VEC_R65  = 16'h0034;
  localparam logic [15:0] VEC_R55  = 16'h002C;

  localparam int unsigned SIM_SOD = 7;
  localparam int unsigned SIM_SOE = 6;
  localparam int unsigned SIM_R75 = 4;
  localparam int unsigned SIM_MSE = 3;
  localparam int unsigned SIM_M75 = 2;
  localparam int unsigned SIM_M65 = 1;
  localparam int unsigned SIM_M55 = 0;

  localparam int unsigned RIM_SID = 7;
  localparam int unsigned RIM_I75 = 6;
  localparam int unsigned RIM_I65 = 5;
  localparam int unsigned RIM_I55 = 4;
  localparam int unsigned RIM_IE  = 3;

  localparam int unsigned PIN_TRAP = 0;
  localparam int unsigned PIN_R75  = 1;
  localparam int unsigned PIN_R65  = 2;
  localparam int unsigned PIN_R55  = 3;
  localparam int unsigned PIN_INTR = 4;
  localparam int unsigned PIN_SID  = 5;
  localparam int unsigned NUM_PINS = 6;

  function automatic logic [15:0] src_vec(input src_e src);
    case (src)
      SRC_TRAP: src_vec = VEC_TRAP;
      SRC_R75:  src_vec = VEC_R75;
      SRC_R65:  src_vec = VEC_R65;
      SRC_R55:  src_vec = VEC_R55;
      default:  src_vec = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/intr85_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a one-cycle pulse on
// each synchronised rising edge.
module intr85_sync_edge #(
  parameter int unsigned SYNCSTG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNCSTG-1:0] sync_q;
  logic               prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < int'(SYNCSTG); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNCSTG-1];
    end
  end

  assign level_o = sync_q[SYNCSTG-1];
  assign rise_o  = sync_q[SYNCSTG-1] & ~prev_q;

endmodule

// File: rtl/intr85_ctrl.sv
// 8085-style interrupt controller: pin synchronisation, SIM masks, IE with
// one-instruction EI delay, fixed priority and RIM status.
module intr85_ctrl
  import intr85_pkg::*;
#(
  parameter int unsigned VECSIZE = 16,
  parameter int unsigned SYNCSTG = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trap,
  input  logic               rst75,
  input  logic               rst65,
  input  logic               rst55,
  input  logic               intr,
  input  logic               sid,
  input  logic               inst_end,
  input  logic               int_ack,
  input  logic               ei_set,
  input  logic               di_set,
  input  logic               sim_wr,
  input  logic [7:0]         sim_data,
  output logic               int_req,
  output logic [2:0]         int_src,
  output logic [VECSIZE-1:0] int_vec,
  output logic [7:0]         rim_data,
  output logic               sod
);

  logic [NUM_PINS-1:0] pins;
  logic [NUM_PINS-1:0] lvl;
  logic [NUM_PINS-1:0] rise;

  assign pins = {sid, intr, rst55, rst65, rst75, trap};

  for (genvar g = 0; g < int'(NUM_PINS); g++) begin : g_sync
    intr85_sync_edge #(.SYNCSTG(SYNCSTG)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .d_i     (pins[g]),
      .level_o (lvl[g]),
      .rise_o  (rise[g])
    );
  end

  logic       ie_q, ie_d;
  logic       arm_q, arm_d;
  logic [2:0] mask_q, mask_d;
  logic       trap_lat_q, trap_lat_d;
  logic       r75_lat_q, r75_lat_d;
  logic       ie_saved_q, ie_saved_d;
  logic       show_saved_q, show_saved_d;
  logic       sod_q, sod_d;

  logic       ie_eff_c;
  logic       ack_c;
  src_e       src_c;
  logic       unused_c;

  assign unused_c = ^{rise[PIN_SID], rise[PIN_INTR], rise[PIN_R55], rise[PIN_R65],
                      sim_data[5]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q         <= 1'b0;
      arm_q        <= 1'b0;
      mask_q       <= 3'b111;
      trap_lat_q   <= 1'b0;
      r75_lat_q    <= 1'b0;
      ie_saved_q   <= 1'b0;
      show_saved_q <= 1'b0;
      sod_q        <= 1'b0;
    end else begin
      ie_q         <= ie_d;
      arm_q        <= arm_d;
      mask_q       <= mask_d;
      trap_lat_q   <= trap_lat_d;
      r75_lat_q    <= r75_lat_d;
      ie_saved_q   <= ie_saved_d;
      show_saved_q <= show_saved_d;
      sod_q        <= sod_d;
    end
  end

  // Fixed priority; TRAP bypasses IE and masks.
  always_comb begin
    src_c    = SRC_NONE;
    ie_eff_c = ie_q | arm_q;
    if (trap_lat_q && lvl[PIN_TRAP])                        src_c = SRC_TRAP;
    else if (ie_eff_c && r75_lat_q && !mask_q[SIM_M75])     src_c = SRC_R75;
    else if (ie_eff_c && lvl[PIN_R65] && !mask_q[SIM_M65])  src_c = SRC_R65;
    else if (ie_eff_c && lvl[PIN_R55] && !mask_q[SIM_M55])  src_c = SRC_R55;
    else if (ie_eff_c && lvl[PIN_INTR])                     src_c = SRC_INTR;
  end

  assign ack_c = int_ack & inst_end;

  // Later assignments take precedence: DI over EI, acknowledge over EI,
  // a new RST7.5 edge over any clear of its latch.
  always_comb begin
    ie_d         = ie_q;
    arm_d        = arm_q;
    mask_d       = mask_q;
    trap_lat_d   = trap_lat_q;
    r75_lat_d    = r75_lat_q;
    ie_saved_d   = ie_saved_q;
    show_saved_d = show_saved_q;
    sod_d        = sod_q;

    if (inst_end && arm_q) begin
      ie_d  = 1'b1;
      arm_d = 1'b0;
    end
    if (ei_set) begin
      arm_d        = 1'b1;
      show_saved_d = 1'b0;
    end
    if (di_set) begin
      ie_d         = 1'b0;
      arm_d        = 1'b0;
      show_saved_d = 1'b0;
    end
    if (ack_c) begin
      ie_d  = 1'b0;
      arm_d = 1'b0;
      if (src_c == SRC_TRAP) begin
        trap_lat_d   = 1'b0;
        ie_saved_d   = ie_q;
        show_saved_d = 1'b1;
      end else begin
        show_saved_d = 1'b0;
      end
      if (src_c == SRC_R75) r75_lat_d = 1'b0;
    end
    if (sim_wr) begin
      if (sim_data[SIM_R75]) r75_lat_d = 1'b0;
      if (sim_data[SIM_MSE]) mask_d = sim_data[2:0];
      if (sim_data[SIM_SOE]) sod_d = sim_data[SIM_SOD];
    end
    if (rise[PIN_R75])  r75_lat_d  = 1'b1;
    if (rise[PIN_TRAP]) trap_lat_d = 1'b1;
  end

  assign int_req = (src_c != SRC_NONE);
  assign int_src = 3'(src_c);
  assign int_vec = VECSIZE'(src_vec(src_c));
  assign sod     = sod_q;

  always_comb begin
    rim_data          = {5'b0, mask_q};
    rim_data[RIM_SID] = lvl[PIN_SID];
    rim_data[RIM_I75] = r75_lat_q;
    rim_data[RIM_I65] = lvl[PIN_R65];
    rim_data[RIM_I55] = lvl[PIN_R55];
    rim_data[RIM_IE]  = show_saved_q ? ie_saved_q : ie_q;
  end

endmodule

// File: tb/tb_intr85_ctrl.sv
// Directed bench for intr85_ctrl with hand-computed expectations.
module tb_intr85_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap, rst75, rst65, rst55, intr, sid;
  logic        inst_end, int_ack, ei_set, di_set, sim_wr;
  logic [7:0]  sim_data;
  logic        int_req;
  logic [2:0]  int_src;
  logic [15:0] int_vec;
  logic [7:0]  rim_data;
  logic        sod;

  int total = 0;
  int bad   = 0;

  intr85_ctrl #(.VECSIZE(16), .SYNCSTG(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .trap     (trap),
    .rst75    (rst75),
    .rst65    (rst65),
    .rst55    (rst55),
    .intr     (intr),
    .sid      (sid),
    .inst_end (inst_end),
    .int_ack  (int_ack),
    .ei_set   (ei_set),
    .di_set   (di_set),
    .sim_wr   (sim_wr),
    .sim_data (sim_data),
    .int_req  (int_req),
    .int_src  (int_src),
    .int_vec  (int_vec),
    .rim_data (rim_data),
    .sod      (sod)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_sim(input logic [7:0] v);
    sim_wr = 1'b1; sim_data = v;
    tick();
    sim_wr = 1'b0; sim_data = 8'h00;
  endtask

  task automatic do_ei_boundary();
    ei_set = 1'b1; inst_end = 1'b1;
    tick();
    ei_set = 1'b0; inst_end = 1'b0;
  endtask

  task automatic do_inst_end();
    inst_end = 1'b1;
    tick();
    inst_end = 1'b0;
  endtask

  task automatic do_ack();
    inst_end = 1'b1; int_ack = 1'b1;
    tick();
    inst_end = 1'b0; int_ack = 1'b0;
  endtask

  task automatic do_di();
    di_set = 1'b1;
    tick();
    di_set = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (rim_data !== 8'h07) begin bad++; $display("FAIL reset_rim: got %h want %h", rim_data, 8'h07); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want %b", int_req, 1'b0); end
    total++; if (int_src !== 3'd0) begin bad++; $display("FAIL reset_src: got %0d want %0d", int_src, 0); end
    total++; if (int_vec !== 16'h0000) begin bad++; $display("FAIL reset_vec: got %h want %h", int_vec, 16'h0000); end
    total++; if (sod !== 1'b0) begin bad++; $display("FAIL reset_sod: got %b want %b", sod, 1'b0); end
  endtask

  task automatic test_ei_r55();
    do_sim(8'h08);
    rst55 = 1'b1;
    tick(3);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL r55_ie_off: got %b want %b", int_req, 1'b0); end
    ei_set = 1'b1; inst_end = 1'b1;
    #1;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL r55_ei_boundary: got %b want %b", int_req, 1'b0); end
    tick();
    ei_set = 1'b0; inst_end = 1'b0;
    inst_end = 1'b1;
    #1;
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL r55_next_req: got %b want %b", int_req, 1'b1); end
    total++; if (int_src !== 3'd4) begin bad++; $display("FAIL r55_next_src: got %0d want %0d", int_src, 4); end
    total++; if (int_vec !== 16'h002C) begin bad++; $display("FAIL r55_next_vec: got %h want %h", int_vec, 16'h002C); end
    tick();
    inst_end = 1'b0;
    do_ack();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL r55_ack_req: got %b want %b", int_req, 1'b0); end
    total++; if (rim_data !== 8'h10) begin bad++; $display("FAIL r55_ack_rim: got %h want %h", rim_data, 8'h10); end
    rst55 = 1'b0;
    tick(3);
  endtask

  task automatic test_priority();
    do_ei_boundary();
    do_inst_end();
    rst75 = 1'b1; rst65 = 1'b1; intr = 1'b1;
    tick();
    rst75 = 1'b0;
    tick(3);
    total++; if (int_src !== 3'd2) begin bad++; $display("FAIL prio_r75_src: got %0d want %0d", int_src, 2); end
    total++; if (int_vec !== 16'h003C) begin bad++; $display("FAIL prio_r75_vec: got %h want %h", int_vec, 16'h003C); end
    do_ack();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL prio_ack_req: got %b want %b", int_req, 1'b0); end
    total++; if (rim_data !== 8'h20) begin bad++; $display("FAIL prio_ack_rim: got %h want %h", rim_data, 8'h20); end
    tick(2);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL prio_wait_req: got %b want %b", int_req, 1'b0); end
    do_ei_boundary();
    total++; if (int_src !== 3'd3) begin bad++; $display("FAIL prio_r65_src: got %0d want %0d", int_src, 3); end
    total++; if (int_vec !== 16'h0034) begin bad++; $display("FAIL prio_r65_vec: got %h want %h", int_vec, 16'h0034); end
    do_sim(8'h0A);
    total++; if (int_src !== 3'd5) begin bad++; $display("FAIL prio_intr_src: got %0d want %0d", int_src, 5); end
    total++; if (int_vec !== 16'h0000) begin bad++; $display("FAIL prio_intr_vec: got %h want %h", int_vec, 16'h0000); end
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL prio_intr_req: got %b want %b", int_req, 1'b1); end
    rst65 = 1'b0; intr = 1'b0;
    do_di();
    tick(3);
  endtask

  task automatic test_trap();
    do_ei_boundary();
    do_inst_end();
    trap = 1'b1;
    tick(3);
    total++; if (int_src !== 3'd1) begin bad++; $display("FAIL trap_src: got %0d want %0d", int_src, 1); end
    total++; if (int_vec !== 16'h0024) begin bad++; $display("FAIL trap_vec: got %h want %h", int_vec, 16'h0024); end
    trap = 1'b0;
    tick(2);
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL trap_drop_req: got %b want %b", int_req, 1'b0); end
    trap = 1'b1;
    tick(3);
    total++; if (int_src !== 3'd1) begin bad++; $display("FAIL trap_again_src: got %0d want %0d", int_src, 1); end
    do_ack();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL trap_ack_req: got %b want %b", int_req, 1'b0); end
    total++; if (rim_data !== 8'h0A) begin bad++; $display("FAIL trap_ack_rim: got %h want %h", rim_data, 8'h0A); end
    do_di();
    total++; if (rim_data[3] !== 1'b0) begin bad++; $display("FAIL trap_di_ie: got %b want %b", rim_data[3], 1'b0); end
    trap = 1'b0;
    tick(3);
  endtask

  task automatic test_r75_mask();
    do_sim(8'h0F);
    do_ei_boundary();
    do_inst_end();
    rst75 = 1'b1;
    tick();
    rst75 = 1'b0;
    tick(3);
    total++; if (rim_data !== 8'h4F) begin bad++; $display("FAIL r75m_rim: got %h want %h", rim_data, 8'h4F); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL r75m_req: got %b want %b", int_req, 1'b0); end
    do_sim(8'h10);
    total++; if (rim_data[6] !== 1'b0) begin bad++; $display("FAIL r75m_clear: got %b want %b", rim_data[6], 1'b0); end
    rst75 = 1'b1;
    tick();
    rst75 = 1'b0;
    tick();
    do_sim(8'h10);
    total++; if (rim_data[6] !== 1'b1) begin bad++; $display("FAIL r75m_set_wins: got %b want %b", rim_data[6], 1'b1); end
    do_sim(8'h10);
    total++; if (rim_data[6] !== 1'b0) begin bad++; $display("FAIL r75m_reclear: got %b want %b", rim_data[6], 1'b0); end
  endtask

  task automatic test_sod();
    do_sim(8'hC0);
    total++; if (sod !== 1'b1) begin bad++; $display("FAIL sod_set: got %b want %b", sod, 1'b1); end
    do_sim(8'h80);
    total++; if (sod !== 1'b1) begin bad++; $display("FAIL sod_hold: got %b want %b", sod, 1'b1); end
    do_sim(8'h40);
    total++; if (sod !== 1'b0) begin bad++; $display("FAIL sod_clr: got %b want %b", sod, 1'b0); end
    sid = 1'b1;
    tick(2);
    total++; if (rim_data[7] !== 1'b1) begin bad++; $display("FAIL sid_rim: got %b want %b", rim_data[7], 1'b1); end
    sid = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    do_sim(8'h08);
    do_sim(8'hC0);
    do_ei_boundary();
    rst55 = 1'b1;
    tick(3);
    total++; if (int_src !== 3'd4) begin bad++; $display("FAIL rmid_pre_src: got %0d want %0d", int_src, 4); end
    #3 rst = 1'b1;
    #1;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rmid_req: got %b want %b", int_req, 1'b0); end
    total++; if (int_vec !== 16'h0000) begin bad++; $display("FAIL rmid_vec: got %h want %h", int_vec, 16'h0000); end
    total++; if (rim_data !== 8'h07) begin bad++; $display("FAIL rmid_rim: got %h want %h", rim_data, 8'h07); end
    total++; if (sod !== 1'b0) begin bad++; $display("FAIL rmid_sod: got %b want %b", sod, 1'b0); end
    tick();
    rst = 1'b0; rst55 = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    trap = 1'b0; rst75 = 1'b0; rst65 = 1'b0; rst55 = 1'b0; intr = 1'b0; sid = 1'b0;
    inst_end = 1'b0; int_ack = 1'b0; ei_set = 1'b0; di_set = 1'b0;
    sim_wr = 1'b0; sim_data = 8'h00;
    tick(3);
    test_reset();
    rst = 1'b0;
    tick();
    test_ei_r55();
    test_priority();
    test_trap();
    test_r75_mask();
    test_sod();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intr85_ctrl.md
Name: intr85_ctrl

Overview:
- Interrupt controller for the core85 8085-compatible processor.
- Takes the pins TRAP, RST7.5, RST6.5, RST5.5 and INTR, plus SID/SOD, and applies the SIM masks, the IE flag and fixed priority.
- Presents one prioritised request, a source code and a vector to the core's control sequencer at each instruction boundary.
- Supplies the RIM status byte and updates state on the core's SIM, EI and DI strobes.

Parameters:
- VECSIZE, 16, width of the vector address output (matches core ADDRSIZE).
- SYNCSTG, 2, synchroniser depth for the asynchronous pins.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- trap  in  1  TRAP pin; edge- and level-sensitive; non-maskable.
- rst75  in  1  RST7.5 pin; rising-edge latched.
- rst65  in  1  RST6.5 pin; level-sensitive.
- rst55  in  1  RST5.5 pin; level-sensitive.
- intr  in  1  INTR pin; level-sensitive; vector supplied externally via INTA.
- sid  in  1  serial input data pin.
- inst_end  in  1  one-cycle pulse from core at each instruction boundary.
- int_ack  in  1  one-cycle pulse from core: request accepted (valid only with inst_end).
- ei_set  in  1  EI executed; pulsed coincident with EI's inst_end.
- di_set  in  1  DI executed.
- sim_wr  in  1  SIM executed; sim_data is valid.
- sim_data  in  8  accumulator value for SIM.
- int_req  out  1  an interrupt is pending and allowed.
- int_src  out  3  source: 0 none, 1 TRAP, 2 R7.5, 3 R6.5, 4 R5.5, 5 INTR.
- int_vec  out  VECSIZE  restart address; 0 for INTR and for none.
- rim_data  out  8  RIM byte: {SID, I7.5, I6.5, I5.5, IE, M7.5, M6.5, M5.5}.
- sod  out  1  serial output data pin.

Behaviour:
- Reset values (asynchronous):
  - IE=0, ie_arm=0, masks=3'b111, trap_lat=0, r75_lat=0, ie_saved=0, sod=0, synchronisers=0.
  - Resulting outputs: int_req=0, int_src=0, int_vec=0, rim_data=8'h07 (with sid low).
- Synchronisation:
  - All pins pass through a SYNCSTG-flop synchroniser.
  - Rising-edge detection compares the synchronised value with its previous value.
  - A pin rise becomes visible on int_req by the 3rd rising clk edge after it.
- TRAP:
  - trap_lat is set on a synchronised rising edge and cleared on an acknowledge of source 1.
  - Request = trap_lat AND synchronised trap level. If the pin drops before acknowledge, the request is withdrawn but the latch remains.
  - Not gated by IE or masks.
- RST7.5:
  - r75_lat is set on a synchronised rising edge.
  - Cleared on an acknowledge of source 2, or on sim_wr with sim_data[4]=1.
  - If a new edge and a clear occur in the same cycle, set wins.
  - Request = r75_lat AND NOT M7.5.
- RST6.5 and RST5.5: request = synchronised level AND NOT the corresponding mask. No latch.
- INTR: request = synchronised level. Not maskable by SIM.
- Maskable enable: ie_eff = IE OR ie_arm. All sources except TRAP are gated by ie_eff.
- Priority: TRAP > R7.5 > R6.5 > R5.5 > INTR.
- Outputs:
  - int_req, int_src and int_vec are combinational from registered state.
  - Vectors: TRAP 16'h0024, R7.5 16'h003C, R6.5 16'h0034, R5.5 16'h002C.
- EI and DI:
  - ei_set sets ie_arm.
  - At the next inst_end with ie_arm=1: IE<=1 and ie_arm<=0.
  - Consequence: no maskable request is seen at EI's own boundary, but one is taken at the boundary of the following instruction.
  - di_set clears IE and ie_arm. If ei_set and di_set occur together, DI wins.
- Acknowledge:
  - int_ack clears IE and ie_arm and clears the latch of the acknowledged source.
  - On a TRAP acknowledge, ie_saved<=IE before clearing. RIM bit 3 then reports ie_saved until the next EI, DI or non-TRAP acknowledge.
  - If int_ack and ei_set occur together, the acknowledge wins.
- SIM:
  - If sim_data[3]=1 (MSE): masks<=sim_data[2:0].
  - If sim_data[6]=1 (SOE): sod<=sim_data[7]; otherwise sod holds.
  - Effects are visible from the next cycle.
- RIM: combinational.
  - Bit 7 = synchronised sid.
  - Bit 6 = r75_lat, shown regardless of mask.
  - Bits 5:4 = synchronised 6.5 and 5.5 levels.
  - Bit 3 = IE, or ie_saved after a TRAP.
- Reset mid-operation: all latches and arms are dropped immediately; pending edges are lost.

Decomposition:
- Package intr85_pkg:
  - Source codes SRC_NONE … SRC_INTR.
  - Vector constants VEC_TRAP, VEC_R75, VEC_R65, VEC_R55.
  - SIM bit indices (SOD, SOE, R75, MSE, M75, M65, M55).
  - RIM bit indices.
- One sub-module: intr85_sync_edge (SYNCSTG-flop synchroniser plus rising-edge pulse), instantiated once per pin.

Test Plan:
- Reset, sid=0 -> rim_data=8'h07, int_req=0, sod=0. Assert rst mid-request -> all outputs return to reset values in the same cycle.
- SIM 8'h08, then EI pulse with inst_end; rst55=1 -> int_req stays 0 at EI's boundary.
  - Next inst_end -> int_req=1, int_src=4, int_vec=16'h002C.
  - int_ack -> int_req=0 next cycle, rim_data[3]=0.
- Masks clear, IE=1, rst75 pulsed 1 cycle, rst65=1, intr=1:
  - -> int_src=2, int_vec=16'h003C.
  - After ack -> int_req=0 until EI.
  - Then -> int_src=3, int_vec=16'h0034.
  - With rst65 masked (SIM 8'h0A) -> int_src=5, int_vec=0.
- IE=1, trap rises and holds -> int_src=1, int_vec=16'h0024.
  - Drop trap before ack -> int_req=0.
  - Raise again and ack -> latch cleared; rim_data[3]=1 (saved IE) while int_req=0.
- SIM 8'h0F masks all; rst75 edge -> rim_data[6]=1, int_req=0.
  - SIM 8'h10 -> rim_data[6]=0.
  - New rst75 edge in the same cycle as SIM 8'h10 -> rim_data[6] stays 1.
- SIM 8'hC0 -> sod=1. SIM 8'h80 -> sod stays 1. SIM 8'h40 -> sod=0.
